// File: rtl/cpu_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_init_sequencer
//  Purpose  : Boot-time loader that walks the init ROM to preload the BTB,
//             the BHT and the register file, then releases the CPU.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_init_sequencer #(
    parameter int BTB_DEPTH = 256,
    parameter int BHT_DEPTH = 256,
    parameter int REG_DEPTH = 32,
    parameter int BTB_W     = 40,
    parameter int ROM_AW    = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    input  logic                         stop,
    output logic [ROM_AW-1:0]            rom_addr,
    input  logic [BTB_W-1:0]             rom_data,
    output logic                         btb_we,
    output logic [$clog2(BTB_DEPTH)-1:0] btb_addr,
    output logic [BTB_W-1:0]             btb_init,
    output logic                         bht_we,
    output logic [$clog2(BHT_DEPTH)-1:0] bht_addr,
    output logic [1:0]                   bht_init,
    output logic                         reg_we,
    output logic [$clog2(REG_DEPTH)-1:0] reg_addr,
    output logic [31:0]                  reg_init,
    output logic                         init_mode,
    output logic                         cpu_start,
    output logic                         busy,
    output logic                         done
);

    localparam int BHT_AW = $clog2(BHT_DEPTH);
    localparam int REG_AW = $clog2(REG_DEPTH);
    localparam int BTB_AW = $clog2(BTB_DEPTH);

    localparam logic [ROM_AW:0] c_BHT_BASE = (ROM_AW+1)'(BTB_DEPTH);
    localparam logic [ROM_AW:0] c_REG_BASE = (ROM_AW+1)'(BTB_DEPTH + BHT_DEPTH);
    localparam logic [ROM_AW:0] c_TOTAL    = (ROM_AW+1)'(BTB_DEPTH + BHT_DEPTH + REG_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ROM_AW:0]     r_idx;
    logic [ROM_AW-1:0]   r_rom_addr;
    logic                r_issue_valid;
    logic [ROM_AW:0]     r_wr_idx;
    logic                r_btb_we;
    logic                r_bht_we;
    logic                r_reg_we;
    logic                r_done;
    logic [ROM_AW:0]     w_issue_idx;

    assign w_issue_idx = {1'b0, r_rom_addr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (go) w_next_state = S_LOAD;
            S_LOAD:  if (r_idx == c_TOTAL) w_next_state = S_DRAIN;
            S_DRAIN: w_next_state = S_DONE;
            S_DONE:  if (stop) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Issue stage registers rom_addr; the write stage decodes the address one
    // edge later, when the ROM has returned the matching word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= '0;
            r_rom_addr    <= '0;
            r_issue_valid <= 1'b0;
            r_wr_idx      <= '0;
            r_btb_we      <= 1'b0;
            r_bht_we      <= 1'b0;
            r_reg_we      <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_issue_valid <= 1'b0;
            if (r_state == S_IDLE && go) begin
                r_idx <= '0;
            end else if (r_state == S_LOAD && r_idx != c_TOTAL) begin
                r_rom_addr    <= r_idx[ROM_AW-1:0];
                r_idx         <= r_idx + 1'b1;
                r_issue_valid <= 1'b1;
            end
            r_wr_idx <= w_issue_idx;
            r_btb_we <= r_issue_valid && (w_issue_idx < c_BHT_BASE);
            r_bht_we <= r_issue_valid && (w_issue_idx >= c_BHT_BASE) && (w_issue_idx < c_REG_BASE);
            // Strictly greater: register x0 is hard-wired and never written.
            r_reg_we <= r_issue_valid && (w_issue_idx > c_REG_BASE);
            r_done   <= (r_state == S_DRAIN);
        end
    end

    assign rom_addr  = r_rom_addr;
    assign btb_we    = r_btb_we;
    assign btb_addr  = r_wr_idx[BTB_AW-1:0];
    assign btb_init  = r_btb_we ? rom_data : '0;
    assign bht_we    = r_bht_we;
    assign bht_addr  = BHT_AW'(r_wr_idx - c_BHT_BASE);
    assign bht_init  = r_bht_we ? rom_data[1:0] : 2'b00;
    assign reg_we    = r_reg_we;
    assign reg_addr  = REG_AW'(r_wr_idx - c_REG_BASE);
    assign reg_init  = r_reg_we ? rom_data[31:0] : 32'd0;
    assign init_mode = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign busy      = init_mode;
    assign cpu_start = (r_state == S_DONE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cpu_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_init_sequencer
//  Purpose  : Self-checking bench for cpu_init_sequencer against a timeline
//             model of the boot load.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_init_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        stop;
    logic [9:0]  rom_addr;
    logic [39:0] rom_data = '0;
    logic        btb_we;
    logic [7:0]  btb_addr;
    logic [39:0] btb_init;
    logic        bht_we;
    logic [7:0]  bht_addr;
    logic [1:0]  bht_init;
    logic        reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_init;
    logic        init_mode;
    logic        cpu_start;
    logic        busy;
    logic        done;

    int checks = 0;
    int passed = 0;
    int cnt_btb, cnt_bht, cnt_reg, cnt_done;

    logic [39:0] rom [0:1023];

    cpu_init_sequencer dut (
        .clk(clk), .rst(rst), .go(go), .stop(stop),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .btb_we(btb_we), .btb_addr(btb_addr), .btb_init(btb_init),
        .bht_we(bht_we), .bht_addr(bht_addr), .bht_init(bht_init),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_init(reg_init),
        .init_mode(init_mode), .cpu_start(cpu_start), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Model: 0 idle, 1 loading, 2 done; m_n counts edges since the go-sample edge.
    int m_mode = 0;
    int m_n = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0;
            m_n    = 0;
        end else begin
            case (m_mode)
                0: if (go) begin m_mode = 1; m_n = 0; end
                1: begin m_n++; if (m_n == 546) m_mode = 2; end
                default: begin m_n++; if (stop) m_mode = 0; end
            endcase
        end
    end

    always @(negedge clk) begin : cmp
        int k;
        bit loading, e_btb, e_bht, e_reg;
        loading = (m_mode == 1);
        k       = m_n - 2;
        e_btb   = loading && k >= 0   && k < 256;
        e_bht   = loading && k >= 256 && k < 512;
        e_reg   = loading && k >= 513 && k < 544;
        check("init_mode", init_mode, loading);
        check("busy", busy, loading);
        check("cpu_start", cpu_start, m_mode == 2);
        check("done", done, (m_mode == 2) && (m_n == 546));
        check("btb_we", btb_we, e_btb);
        check("bht_we", bht_we, e_bht);
        check("reg_we", reg_we, e_reg);
        if (e_btb) begin
            check("btb_addr", btb_addr, k);
            check("btb_init", btb_init, rom[k]);
        end
        if (e_bht) begin
            check("bht_addr", bht_addr, k - 256);
            check("bht_init", bht_init, rom[k] & 40'h3);
        end
        if (e_reg) begin
            check("reg_addr", reg_addr, k - 512);
            check("reg_init", reg_init, rom[k] & 40'hFFFF_FFFF);
        end
        if (loading && m_n >= 1)
            check("rom_addr", rom_addr, (m_n >= 545) ? 543 : m_n - 1);
        check("we_exclusive", ($countones({btb_we, bht_we, reg_we}) <= 1), 1'b1);
        check("mode_and_start", init_mode && cpu_start, 1'b0);
        if (btb_we || bht_we || reg_we) check("strobe_in_init", init_mode, 1'b1);
        if (reg_we) check("reg_x0_write", reg_addr == 5'd0, 1'b0);
        if (btb_we) cnt_btb++;
        if (bht_we) cnt_bht++;
        if (reg_we) cnt_reg++;
        if (done)   cnt_done++;
    end

    task automatic fill_rom(input bit ident);
        logic [63:0] t;
        for (int i = 0; i < 1024; i++) begin
            t = {$urandom(), $urandom()};
            rom[i] = ident ? 40'(i) : t[39:0];
        end
    endtask

    task automatic run_load(input bit hold_go, input bit with_stop);
        int edges;
        cnt_btb = 0; cnt_bht = 0; cnt_reg = 0; cnt_done = 0;
        @(negedge clk);
        go   = 1'b1;
        stop = with_stop;
        @(posedge clk);
        #1;
        if (!hold_go) go = 1'b0;
        stop  = 1'b0;
        edges = 0;
        while (!cpu_start && edges < 1000) begin
            @(posedge clk);
            edges++;
            #1;
        end
        go = 1'b0;
        check("go_to_cpu_start_edges", edges, 546);
        @(negedge clk);
        @(negedge clk);
        check("btb_we_count", cnt_btb, 256);
        check("bht_we_count", cnt_bht, 256);
        check("reg_we_count", cnt_reg, 31);
        check("done_pulses", cnt_done, 1);
    endtask

    task automatic stop_pulse();
        repeat ($urandom_range(1, 5)) @(negedge clk);
        check("cpu_start_before_stop", cpu_start, 1'b1);
        stop = 1'b1;
        @(posedge clk);
        #1;
        check("stop_drops_cpu_start", cpu_start, 1'b0);
        stop = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
    endtask

    initial begin
        int wait_n;
        rst  = 1'b1;
        go   = 1'b0;
        stop = 1'b0;
        fill_rom(1'b1);
        rom[512] = 40'hDE_ADBE_EF;
        repeat (3) @(negedge clk);
        check("reset_init_mode", init_mode, 1'b0);
        check("reset_cpu_start", cpu_start, 1'b0);
        check("reset_rom_addr", rom_addr, 10'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Identity ROM: btb_init=k, reg_init=513..543, x0 slot holds DEADBEEF.
        run_load(1'b0, 1'b0);
        stop_pulse();

        fill_rom(1'b0);
        run_load(1'b1, 1'b0);
        stop_pulse();

        fill_rom(1'b0);
        run_load(1'b0, 1'b1);
        stop_pulse();

        // Asynchronous abort while issuing index 300.
        fill_rom(1'b0);
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        wait_n = 0;
        while (m_n != 301 && wait_n < 1000) begin
            @(negedge clk);
            wait_n++;
        end
        check("reach_idx300", rom_addr, 10'd300);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_ctrl",
              {btb_we, bht_we, reg_we, init_mode, cpu_start, busy, done, rom_addr, btb_addr, bht_addr, reg_addr},
              '0);
        check("rst_async_data", {btb_init, bht_init, reg_init}, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_load(1'b0, 1'b0);
        stop_pulse();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_init_sequencer.md
Name: cpu_init_sequencer

Overview:
- Boot-time controller for the 5-stage pipelined CPU.
- After `go`, it walks a unified init ROM and preloads three structures in order: the BTB (256×40), the BHT (256×2) and the register file (32×32).
- During the load it holds the CPU in init mode. When the load completes it releases the CPU by asserting `cpu_start`.
- It sits between the board-level control and the CPU top: it drives `btb_addr`/`btb_init`, `bht_addr`/`bht_init`, `reg_addr`/`reg_init`, `init_mode` (to `rst_switch`) and `cpu_start` (to `start_switch`).

Parameters:
- BTB_DEPTH, 256, number of BTB entries (power of 2)
- BHT_DEPTH, 256, number of BHT entries (power of 2)
- REG_DEPTH, 32, number of architectural registers
- BTB_W, 40, BTB entry width; also the ROM data width
- ROM_AW, 10, ROM address width; must satisfy 2^ROM_AW >= BTB_DEPTH+BHT_DEPTH+REG_DEPTH

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- go  in  1  level; start the load sequence when IDLE
- stop  in  1  level; drop `cpu_start` and return to IDLE from DONE
- rom_addr  out  ROM_AW  init ROM read address
- rom_data  in  BTB_W  init ROM read data, valid exactly 1 cycle after `rom_addr`
- btb_we  out  1  BTB write strobe
- btb_addr  out  8  BTB write index
- btb_init  out  40  BTB write data
- bht_we  out  1  BHT write strobe
- bht_addr  out  8  BHT write index
- bht_init  out  2  BHT write data, `rom_data[1:0]`
- reg_we  out  1  register file write strobe
- reg_addr  out  5  register write index
- reg_init  out  32  register write data, `rom_data[31:0]`
- init_mode  out  1  high while loading; drives `rst_switch`
- cpu_start  out  1  high in DONE; drives `start_switch`
- busy  out  1  high in LOAD or DRAIN
- done  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset: all outputs are 0, state is IDLE, the index counter is 0. Reset is asynchronous and active-high. Asserting reset mid-load aborts immediately; the next `go` restarts from index 0.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE → LOAD when `go`=1. `go` is ignored in every other state.
- LOAD, issue side:
  - Each cycle: `rom_addr` = idx, then idx += 1.
  - idx 0..255 is the BTB phase, 256..511 the BHT phase, 512..543 the REG phase.
  - When idx = 543 has been issued, the next state is DRAIN.
- LOAD, write side (pipelined, 1-cycle latency):
  - A delayed copy of idx and a valid bit are registered alongside the issue.
  - In the cycle after issue, exactly one of `btb_we`/`bht_we`/`reg_we` is high, chosen by the delayed phase.
  - Write index = delayed idx minus the phase base, truncated to 8 or 5 bits.
  - Write data: `btb_init` = `rom_data`, `bht_init` = `rom_data[1:0]`, `reg_init` = `rom_data[31:0]`.
- Register x0 is never written: `reg_we` stays 0 for delayed idx 512. `reg_addr`/`reg_init` may still show the value.
- DRAIN: exactly one cycle. It performs the final write (register 31). `rom_addr` holds its last value. Next state is DONE.
- `init_mode`:
  - Goes high on the first clock edge of LOAD.
  - Stays high through DRAIN.
  - Goes low on entry to DONE.
- `cpu_start`: goes high on entry to DONE, the same edge on which `init_mode` falls.
- DONE:
  - `done` pulses once on entry.
  - `cpu_start` is held high while `stop`=0.
  - `stop`=1 → IDLE, with `cpu_start` low on the following edge.
- IDLE after `stop` does not preserve table contents; a new `go` fully reloads.
- Write-strobe timing: strobes are registered. The first `btb_we` is seen 2 edges after the IDLE → LOAD edge.
- Totals:
  - Write strobes: 544 cycles (256 `btb_we`, 256 `bht_we`, 31 `reg_we`, plus 1 suppressed x0 slot).
  - From go-sample edge to `cpu_start`=1: 546 edges.
- Data bits not used by a phase are ignored. `btb_init`, `bht_init` and `reg_init` are don't-care when the matching `we` is 0.
- Simultaneous `go` and `stop` in IDLE: `go` wins. `stop` in IDLE, LOAD or DRAIN is ignored.

Test Plan:
- Reset then `go`=1 for one cycle, ROM[i] = i → `btb_we` 256 cycles with `btb_addr`=k and `btb_init`=k; then `bht_we` with `bht_addr`=k and `bht_init`=(256+k)[1:0]; then `reg_we` 31 cycles, `reg_addr` 1..31, `reg_init`=513..543. `cpu_start` rises exactly 546 edges after go and `done` pulses once.
- ROM[512] = 0xDEADBEEF → no `reg_we` during the x0 slot. Count of `reg_we` = 31 and `reg_addr` is never 0 while `reg_we`=1.
- Assert `rst` asynchronously at idx 300 (mid-BHT) → all outputs are 0 before the next edge and state is IDLE. Re-`go` → `btb_addr` restarts at 0 and the full 546-edge sequence repeats.
- In DONE, pulse `stop` → `cpu_start`=0 next edge. `go` held high throughout LOAD is ignored; `go`+`stop` together in IDLE starts a load.
- Strobe-exclusivity check over a full load: at most one `*_we` high per cycle, `init_mode`=1 on every strobe cycle, and `init_mode`/`cpu_start` never both 1.
